// File: rtl/irrigation_valve_driver.sv
// Irrigation valve/pump sequencer: settle, pump run (min/max bounded), drain, close.
// Define IRRIG_ALTERNATE_EN to serve at most one area per watering cycle (round-robin).
module irrigation_valve_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int MAX_ON_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       fault_clr,
    output logic [1:0] valve,
    output logic       pump,
    output logic       busy,
    output logic [1:0] fault
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_PUMP,
        ST_DRAIN
    } state_e;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MIN_ON      = 16'(MIN_ON_CYCLES);
    localparam logic [15:0] MAX_ON      = 16'(MAX_ON_CYCLES);

    state_e      state_q, state_d;
    logic [1:0]  mask_q, mask_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  fault_q, fault_d;
    logic [1:0]  eff;
    logic [1:0]  pending;
    logic [15:0] on_done;
`ifdef IRRIG_ALTERNATE_EN
    logic        rr_q, rr_d;
`endif

    assign eff     = req & ~fault_q;
    assign pending = req & mask_q;
    // Pump cycles completed including the current one.
    assign on_done = cnt_q + 16'd1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        fault_d = fault_clr ? 2'b00 : fault_q;
`ifdef IRRIG_ALTERNATE_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (eff != 2'b00) begin
`ifdef IRRIG_ALTERNATE_EN
                    if (eff == 2'b11) begin
                        mask_d = rr_q ? 2'b10 : 2'b01;
                        rr_d   = ~rr_q;
                    end else begin
                        mask_d = eff;
                    end
`else
                    mask_d = eff;
`endif
                    cnt_d   = 16'd0;
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_PUMP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_PUMP: begin
                if (on_done >= MIN_ON && pending == 2'b00) begin
                    cnt_d   = 16'd0;
                    state_d = ST_DRAIN;
                end else if (on_done == MAX_ON) begin
                    // A timeout set overrides a simultaneous clear for the newly faulting bits.
                    fault_d = fault_d | pending;
                    cnt_d   = 16'd0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    mask_d  = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                mask_d  = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= 2'b00;
            cnt_q   <= 16'd0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

`ifdef IRRIG_ALTERNATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Moore outputs: decoded from registered state only, so reset clears them immediately.
    assign valve = (state_q != ST_IDLE) ? mask_q : 2'b00;
    assign pump  = (state_q == ST_PUMP);
    assign busy  = (state_q != ST_IDLE);
    assign fault = fault_q;

endmodule
